// File: rtl/score_bcd_display.sv
// BCD score counter with synchronised increment input, sticky win flag and a
// time-multiplexed, active-low seven-segment display driver.
module score_bcd_display #(
  parameter int          NUM_DIGITS = 2,
  parameter logic [15:0] WIN_SCORE  = 16'h0010,
  parameter int          STROBE_MAX = 99999,
  parameter bit          SATURATE   = 1'b0,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARGET_REACHED,
  input  logic                    SCORE_CLR,
  output logic [3:0]              SEG_SELECT,
  output logic [6:0]              DEC_OUT,
  output logic [4*NUM_DIGITS-1:0] SCORE_BCD,
  output logic                    GAME_WON
);

  localparam int              SW        = 4 * NUM_DIGITS;
  localparam int              CW        = (STROBE_MAX > 0) ? $clog2(STROBE_MAX + 1) : 1;
  localparam logic [SW-1:0]   WIN_VAL   = WIN_SCORE[SW-1:0];
  localparam logic [SW-1:0]   ALL_NINES = {NUM_DIGITS{4'h9}};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic          sync_meta, sync_q, sync_prev;
  logic          inc_pulse;
  logic [SW-1:0] score_q, score_inc;
  logic          won_q;
  logic [CW-1:0] strobe_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit_val;
  logic          digit_blank;
  logic [3:0]    seg_next;

  // Two-flop synchroniser, third flop remembers the previous level for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= TARGET_REACHED;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  assign inc_pulse = sync_q & ~sync_prev;

  // Decimal ripple: a digit steps only while every digit below it is rolling over from 9.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic carry;
    score_inc = score_q;
    carry     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (score_q[4*k +: 4] == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
        end else begin
          score_inc[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    if (SATURATE && (score_q == ALL_NINES)) score_inc = score_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      score_q <= '0;
      won_q   <= 1'b0;
    end else if (SCORE_CLR) begin
      score_q <= '0;
      won_q   <= 1'b0;
    end else if (inc_pulse && !won_q) begin
      score_q <= score_inc;
      if ((WIN_VAL != '0) && (score_inc == WIN_VAL)) won_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe_cnt <= '0;
      digit_idx  <= 2'd0;
    end else if (strobe_cnt == CW'(STROBE_MAX)) begin
      strobe_cnt <= '0;
      digit_idx  <= (digit_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      strobe_cnt <= strobe_cnt + 1'b1;
    end
  end

  // Scan from the top digit down so leading-zero status is known when the selected digit is reached.
  always_comb begin
    logic higher_zero;
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (score_q[4*k +: 4] == 4'd0);
      if (digit_idx == 2'(k)) begin
        digit_val   = score_q[4*k +: 4];
        digit_blank = BLANK_LZ && (k != 0) && higher_zero;
      end
    end
    seg_next            = 4'b1111;
    seg_next[digit_idx] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT <= 4'b1110;
      DEC_OUT    <= 7'b1000000;
    end else begin
      SEG_SELECT <= seg_next;
      DEC_OUT    <= digit_blank ? 7'b1111111 : seg7(digit_val);
    end
  end

  assign SCORE_BCD = score_q;
  assign GAME_WON  = won_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench: four differently parameterised score_bcd_display instances
// share one stimulus stream and are compared against an integer-arithmetic model.
module tb_score_bcd_display;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic TARGET_REACHED = 1'b0;
  logic SCORE_CLR = 1'b0;

  always #5 CLK = ~CLK;

  // Instance 0 default, 1 wrap, 2 saturate, 3 three-digit blanking display.
  localparam int P_N   [4] = '{2, 2, 2, 3};
  localparam int P_WIN [4] = '{10, 0, 0, 0};
  localparam int P_SAT [4] = '{0, 0, 1, 0};
  localparam int P_SM  [4] = '{99999, 7, 5, 3};
  localparam int P_BLK [4] = '{0, 0, 0, 1};

  logic [7:0]  sc0, sc1, sc2;
  logic [11:0] sc3;
  logic [3:0]  seg0, seg1, seg2, seg3;
  logic [6:0]  dec0, dec1, dec2, dec3;
  logic        won0, won1, won2, won3;

  score_bcd_display u_def (
    .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TARGET_REACHED), .SCORE_CLR(SCORE_CLR),
    .SEG_SELECT(seg0), .DEC_OUT(dec0), .SCORE_BCD(sc0), .GAME_WON(won0));

  score_bcd_display #(.NUM_DIGITS(2), .WIN_SCORE(16'h0000), .STROBE_MAX(7)) u_wrap (
    .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TARGET_REACHED), .SCORE_CLR(SCORE_CLR),
    .SEG_SELECT(seg1), .DEC_OUT(dec1), .SCORE_BCD(sc1), .GAME_WON(won1));

  score_bcd_display #(.NUM_DIGITS(2), .WIN_SCORE(16'h0000), .STROBE_MAX(5), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TARGET_REACHED), .SCORE_CLR(SCORE_CLR),
    .SEG_SELECT(seg2), .DEC_OUT(dec2), .SCORE_BCD(sc2), .GAME_WON(won2));

  score_bcd_display #(.NUM_DIGITS(3), .WIN_SCORE(16'h0000), .STROBE_MAX(3), .BLANK_LZ(1'b1)) u_disp (
    .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TARGET_REACHED), .SCORE_CLR(SCORE_CLR),
    .SEG_SELECT(seg3), .DEC_OUT(dec3), .SCORE_BCD(sc3), .GAME_WON(won3));

  logic [15:0] obs_score [4];
  logic [3:0]  obs_seg   [4];
  logic [6:0]  obs_dec   [4];
  logic        obs_won   [4];

  assign obs_score[0] = {8'h00, sc0};
  assign obs_score[1] = {8'h00, sc1};
  assign obs_score[2] = {8'h00, sc2};
  assign obs_score[3] = {4'h0, sc3};
  assign obs_seg[0] = seg0;  assign obs_seg[1] = seg1;  assign obs_seg[2] = seg2;  assign obs_seg[3] = seg3;
  assign obs_dec[0] = dec0;  assign obs_dec[1] = dec1;  assign obs_dec[2] = dec2;  assign obs_dec[3] = dec3;
  assign obs_won[0] = won0;  assign obs_won[1] = won1;  assign obs_won[2] = won2;  assign obs_won[3] = won3;

  logic [6:0] seg7_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks = 0;
  int failures = 0;
  int m_val [4];
  bit m_won [4];
  int n_cyc = 0;

  // Rising edges seen since the last reset edge.
  always @(posedge CLK) begin
    if (RESET) n_cyc <= 0;
    else       n_cyc <= n_cyc + 1;
  end

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_seg(input int i);
    int m = (n_cyc > 0) ? n_cyc - 1 : 0;
    int idx = (m / (P_SM[i] + 1)) % P_N[i];
    return 4'hF & ~(4'b0001 << idx);
  endfunction

  function automatic logic [6:0] exp_dec(input int i);
    int m = (n_cyc > 0) ? n_cyc - 1 : 0;
    int idx = (m / (P_SM[i] + 1)) % P_N[i];
    if (P_BLK[i] != 0 && idx > 0 && m_val[i] < pow10(idx)) return 7'b1111111;
    return seg7_tbl[(m_val[i] / pow10(idx)) % 10];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0;
      m_won[i] = 1'b0;
    end
  endtask

  task automatic model_inc();
    for (int i = 0; i < 4; i++) begin
      if (!m_won[i]) begin
        if (m_val[i] == pow10(P_N[i]) - 1) begin
          if (P_SAT[i] == 0) m_val[i] = 0;
        end else begin
          m_val[i] = m_val[i] + 1;
        end
        if (P_WIN[i] != 0 && m_val[i] == P_WIN[i]) m_won[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; TARGET_REACHED = 1'b0; SCORE_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_clear();
  endtask

  // Raise the request and stop just after the edge on which the score must move.
  task automatic rise_to_update();
    @(negedge CLK);
    TARGET_REACHED = 1'b1;
    repeat (3) @(negedge CLK);
    model_inc();
  endtask

  task automatic release_tr();
    repeat ($urandom_range(0, 4)) @(negedge CLK);
    TARGET_REACHED = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge CLK);
  endtask

  task automatic pulse();
    rise_to_update();
    release_tr();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL reset_score[%0d] got %h want 0000", i, obs_score[i]); end
      if (obs_won[i] !== 1'b0)       begin failures++; $display("FAIL reset_won[%0d] got %b want 0", i, obs_won[i]); end
      if (obs_seg[i] !== 4'b1110)    begin failures++; $display("FAIL reset_seg[%0d] got %b want 1110", i, obs_seg[i]); end
      if (obs_dec[i] !== 7'b1000000) begin failures++; $display("FAIL reset_dec[%0d] got %b want 1000000", i, obs_dec[i]); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge CLK);
    TARGET_REACHED = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL early_inc[%0d] got %h want 0000", i, obs_score[i]); end
    end
    @(negedge CLK);
    model_inc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL third_edge_inc[%0d] got %h want %h", i, obs_score[i], to_bcd(m_val[i])); end
    end
    repeat (7) @(negedge CLK);
    TARGET_REACHED = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL held_high_once[%0d] got %h want %h", i, obs_score[i], to_bcd(m_val[i])); end
    end
  endtask

  task automatic test_win();
    do_reset();
    for (int p = 0; p < 11; p++) begin
      rise_to_update();
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL win_score[%0d] pulse %0d got %h want %h", i, p, obs_score[i], to_bcd(m_val[i])); end
        if (obs_won[i] !== m_won[i])           begin failures++; $display("FAIL win_flag[%0d] pulse %0d got %b want %b", i, p, obs_won[i], m_won[i]); end
      end
      release_tr();
    end
    @(negedge CLK);
    SCORE_CLR = 1'b1;
    @(negedge CLK);
    SCORE_CLR = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL clr_score[%0d] got %h want 0000", i, obs_score[i]); end
      if (obs_won[i] !== 1'b0)       begin failures++; $display("FAIL clr_won[%0d] got %b want 0", i, obs_won[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 100; p++) begin
      rise_to_update();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL wrap_score[%0d] pulse %0d got %h want %h", i, p, obs_score[i], to_bcd(m_val[i])); end
      end
      release_tr();
    end
  endtask

  task automatic test_clr_priority();
    do_reset();
    repeat (5) pulse();
    @(negedge CLK);
    TARGET_REACHED = 1'b1;
    repeat (2) @(negedge CLK);
    SCORE_CLR = 1'b1;
    @(negedge CLK);
    SCORE_CLR = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL clr_priority[%0d] got %h want 0000", i, obs_score[i]); end
    end
    release_tr();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL clr_then_hold[%0d] got %h want 0000", i, obs_score[i]); end
    end
  endtask

  task automatic test_display();
    do_reset();
    repeat (7) pulse();
    repeat (2) @(negedge CLK);
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (obs_seg[i] !== exp_seg(i)) begin failures++; $display("FAIL disp_seg[%0d] cyc %0d got %b want %b", i, n_cyc, obs_seg[i], exp_seg(i)); end
        if (obs_dec[i] !== exp_dec(i)) begin failures++; $display("FAIL disp_dec[%0d] cyc %0d got %b want %b", i, n_cyc, obs_dec[i], exp_dec(i)); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge CLK);
        SCORE_CLR = 1'b1;
        @(negedge CLK);
        SCORE_CLR = 1'b0;
        model_clear();
      end else begin
        rise_to_update();
      end
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL rand_score[%0d] step %0d got %h want %h", i, p, obs_score[i], to_bcd(m_val[i])); end
        if (obs_won[i] !== m_won[i])           begin failures++; $display("FAIL rand_won[%0d] step %0d got %b want %b", i, p, obs_won[i], m_won[i]); end
      end
      release_tr();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (37) pulse();
    checks++;
    if (obs_score[1] !== 16'h0037) begin failures++; $display("FAIL pre_reset_score got %h want 0037", obs_score[1]); end
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (obs_score[i] !== 16'h0000) begin failures++; $display("FAIL mid_reset_score[%0d] got %h want 0000", i, obs_score[i]); end
      if (obs_won[i] !== 1'b0)       begin failures++; $display("FAIL mid_reset_won[%0d] got %b want 0", i, obs_won[i]); end
      if (obs_seg[i] !== 4'b1110)    begin failures++; $display("FAIL mid_reset_seg[%0d] got %b want 1110", i, obs_seg[i]); end
      if (obs_dec[i] !== 7'b1000000) begin failures++; $display("FAIL mid_reset_dec[%0d] got %b want 1000000", i, obs_dec[i]); end
    end
  endtask

  task automatic test_release_high();
    @(negedge CLK);
    RESET = 1'b1; TARGET_REACHED = 1'b1; SCORE_CLR = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; SCORE_CLR = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK);
    model_inc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL release_high_inc[%0d] got %h want %h", i, obs_score[i], to_bcd(m_val[i])); end
    end
    release_tr();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_score[i] !== to_bcd(m_val[i])) begin failures++; $display("FAIL release_high_once[%0d] got %h want %h", i, obs_score[i], to_bcd(m_val[i])); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_win();
    test_wrap();
    test_clr_priority();
    test_display();
    test_random();
    test_reset_mid();
    test_release_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 2, number of BCD score digits (legal 1..4).
REQ-002 SHALL provide parameter WIN_SCORE, default 16'h0010, BCD-coded win value, low 4*NUM_DIGITS bits used; 0 disables winning.
REQ-003 SHALL provide parameter STROBE_MAX, default 99999, refresh divider terminal count.
REQ-004 SHALL provide parameter SATURATE, default 0: 0 = wrap all-9s to 0, 1 = hold at all-9s.
REQ-005 SHALL provide parameter BLANK_LZ, default 0: 1 = blank leading-zero digits.
REQ-006 SHALL provide port CLK  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL provide port RESET  input  1  synchronous, active-high reset.
REQ-008 SHALL provide port TARGET_REACHED  input  1  score-increment request, asynchronous level, any duration.
REQ-009 SHALL provide port SCORE_CLR  input  1  synchronous score clear, sampled directly, no synchroniser.
REQ-010 SHALL provide port SEG_SELECT  output  4  active-low digit enables, bit k = digit k.
REQ-011 SHALL provide port DEC_OUT  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 SHALL provide port SCORE_BCD  output  4*NUM_DIGITS  current score, digit 0 in bits [3:0].
REQ-013 SHALL provide port GAME_WON  output  1  sticky win flag.

Function
REQ-014 TARGET_REACHED SHALL pass through a 2-flop synchroniser followed by a rising-edge detector producing a single one-cycle increment pulse per low-to-high transition.
REQ-015 Increment latency SHALL be: SCORE_BCD updates on the 3rd rising CLK edge at which TARGET_REACHED is sampled high.
REQ-016 A held-high TARGET_REACHED SHALL produce exactly one increment.
REQ-017 Increment SHALL be decimal: digit 0 adds 1; digit k adds 1 only when digits 0..k-1 are all 9, those digits becoming 0.
REQ-018 At all-9s with SATURATE=0, an increment SHALL yield all-zero; with SATURATE=1 the score SHALL hold.
REQ-019 SCORE_CLR high SHALL zero the score and clear GAME_WON on the next edge, taking priority over a simultaneous increment.
REQ-020 GAME_WON SHALL be registered and SHALL assert on the edge at which the score becomes equal to WIN_SCORE (WIN_SCORE nonzero).
REQ-021 While GAME_WON is high, increment pulses SHALL be ignored (score frozen); GAME_WON SHALL remain high until RESET or SCORE_CLR.
REQ-022 A free-running strobe counter SHALL count 0..STROBE_MAX and issue a one-cycle tick on the wrap to 0, i.e. every STROBE_MAX+1 cycles.
REQ-023 Each tick SHALL advance the digit index 0,1,..,NUM_DIGITS-1, then back to 0.
REQ-024 SEG_SELECT and DEC_OUT SHALL be registered, reflecting the digit index and score one cycle after they change.
REQ-025 SEG_SELECT SHALL drive low only bit [index]; bits >= NUM_DIGITS SHALL always be high.
REQ-026 DEC_OUT SHALL be the standard decimal 0-9 active-low pattern of the selected digit (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); nibbles 10-15 SHALL not occur.
REQ-027 With BLANK_LZ=1, digit k>0 SHALL output DEC_OUT = 7'b1111111 when it and all higher digits are 0; digit 0 is never blanked.

Reset
REQ-028 On RESET high at a rising edge: score 0, GAME_WON 0, synchroniser and edge-detector flops 0, strobe counter 0, digit index 0, SEG_SELECT 4'b1110, DEC_OUT 7'b1000000.
REQ-029 RESET SHALL override SCORE_CLR and any pending increment; a TARGET_REACHED already high at reset release SHALL produce one increment (rising edge seen by cleared flops).

Verification
REQ-030 Reset then pulse TARGET_REACHED once for 10 cycles -> SCORE_BCD 8'h01 on 3rd edge after first high sample, no further change.
REQ-031 NUM_DIGITS=2, WIN_SCORE=0: 99 pulses -> 8'h99; one more -> 8'h00 (SATURATE=0) or 8'h99 (SATURATE=1).
REQ-032 Default parameters: 10 pulses -> SCORE_BCD 8'h10, GAME_WON 1 same edge; 11th pulse -> score stays 8'h10; SCORE_CLR -> 8'h00, GAME_WON 0.
REQ-033 SCORE_CLR and increment pulse same cycle at score 8'h05 -> score 8'h00.
REQ-034 STROBE_MAX=3, NUM_DIGITS=3, score 12'h007, BLANK_LZ=1 -> SEG_SELECT cycles 1110,1101,1011 every 4 cycles; DEC_OUT 7'b1111000, 7'b1111111, 7'b1111111.
REQ-035 RESET asserted mid-count at score 8'h37 with TARGET_REACHED low -> next edge all outputs at REQ-028 values.
